// File: rtl/add_sched.sv
// rtl/add_sched.sv - round-robin scheduler sharing one registered adder among NREQ requesters
// Define ADD_SCHED_FIXED_PRIO_EN to replace round-robin with lowest-index-wins arbitration.
module add_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_sum,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_sum,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] last;
  logic [IDW-1:0] id;
  logic [IDW-1:0] gnt;
  logic           grant;

  function automatic logic [IDW-1:0] lowest_set(input logic [NREQ-1:0] v);
    lowest_set = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDW'(i);
    end
  endfunction

`ifdef ADD_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt = lowest_set(req_valid);
  end
`else
  logic [NREQ-1:0] above_last;

  // Prefer requesters above the last winner; wrap to the lowest index otherwise.
  always_comb begin
    above_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      above_last[i] = (i > int'(last));
    end
    if ((req_valid & above_last) != '0) gnt = lowest_set(req_valid & above_last);
    else                                gnt = lowest_set(req_valid);
  end
`endif

  assign grant = (state == IDLE) && (req_valid != '0) && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid != '0) state_next = ISSUE;
      ISSUE:   state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      id        <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        add_a <= req_a[int'(gnt)*W +: W];
        add_b <= req_b[int'(gnt)*W +: W];
        id    <= gnt;
        last  <= gnt;
      end
      // The adder sampled add_a/add_b at the end of ISSUE, so add_sum is valid in CAPT.
      if (state == CAPT) begin
        rsp_sum   <= add_sum;
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - scoreboard bench for add_sched with a behavioural registered adder
module tb_add_sched;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W:0]        add_sum;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W:0]        rsp_sum;
  logic              rsp_ready;

  typedef struct {
    int id;
    int sum;
  } exp_t;

  exp_t sb[$];
  int   rsp_cyc[$];
  exp_t e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  add_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    add_sum <= {1'b0, add_a} + {1'b0, add_b};
    cyc     <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got id %0d sum %0d, expected no response", rsp_id, rsp_sum);
      end else begin
        e = sb.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check("rsp_sum", int'(rsp_sum), e.sum);
      end
    end
  end

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]    = 1'b1;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic expect_rsp(input int id, input int sum);
    exp_t x;
    x.id  = id;
    x.sum = sum;
    sb.push_back(x);
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp_rdy, input string name);
    int n = 0;
    logic [NREQ-1:0] got;
    got = '0;
    while (n < 20) begin
      @(negedge clk);
      got = req_ready;
      if (got != '0) break;
      n++;
    end
    check(name, int'(got), int'(exp_rdy));
    @(posedge clk);
    #1;
    req_valid = req_valid & ~got;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_add_ab", int'({add_a, add_b}), 0);
    check("rst_rsp_id_sum", int'({rsp_id, rsp_sum}), 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] one;
    int base;
    int c;
    one       = 1;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();

    // All four requesters at once: rotation 0..3, responses 4 cycles apart.
    base = rsp_cyc.size();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, i, 10);
      expect_rsp(i, 10 + i);
    end
    for (int k = 0; k < NREQ; k++) wait_grant(one << k, "all4_grant");
    drain("all4_drain");
    check("all4_count", rsp_cyc.size() - base, 4);
    if (rsp_cyc.size() - base == 4) begin
      for (int k = 1; k < 4; k++) check("all4_spacing", rsp_cyc[base+k] - rsp_cyc[base+k-1], 4);
    end

    // Single request with exact latency.
    set_req(2, 3, 5);
    expect_rsp(2, 8);
    wait_grant(4'b0100, "single_grant");
    @(negedge clk);
    check("single_ready_drop", int'(req_ready), 0);
    check("single_issue_valid", int'(rsp_valid), 0);
    @(negedge clk);
    check("single_capt_valid", int'(rsp_valid), 0);
    @(negedge clk);
    check("single_rsp_valid", int'(rsp_valid), 1);
    check("single_rsp_id", int'(rsp_id), 2);
    check("single_rsp_sum", int'(rsp_sum), 8);
    @(negedge clk);
    check("single_done_valid", int'(rsp_valid), 0);
    drain("single_drain");

    // Backpressure for 5 cycles while another requester waits.
    rsp_ready = 1'b0;
    set_req(1, 7, 9);
    expect_rsp(1, 16);
    wait_grant(4'b0010, "bp_grant");
    set_req(3, 1, 2);
    expect_rsp(3, 3);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", int'(rsp_valid), 1);
      check("bp_id", int'(rsp_id), 1);
      check("bp_sum", int'(rsp_sum), 16);
      check("bp_req_ready", int'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    c = cyc;
    wait_grant(4'b1000, "bp_next_grant");
    check("bp_consume_cycle", rsp_cyc[rsp_cyc.size()-1], c);
    drain("bp_drain");

    // Maximum operands.
    set_req(0, 15, 15);
    expect_rsp(0, 30);
    wait_grant(4'b0001, "max_grant");
    drain("max_drain");

    // Reset during CAPT drops the transaction and restores priority to requester 0.
    set_req(0, 4, 4);
    wait_grant(4'b0001, "midrst_grant");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 1, 1);
    set_req(1, 2, 2);
    expect_rsp(0, 2);
    expect_rsp(1, 4);
    wait_grant(4'b0001, "midrst_first_grant");
    @(negedge clk);
    check("midrst_no_rsp", int'(rsp_valid), 0);
    wait_grant(4'b0010, "midrst_second_grant");
    drain("midrst_drain");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_sched.md
# add_sched

Round-robin scheduler that shares one registered adder (`a + b`, sum registered on `posedge clk`) among `NREQ` requesters. Each requester offers an operand pair through a valid/ready handshake. The scheduler grants one pair at a time, drives it onto the adder's operand inputs, and captures the registered sum. It then returns the sum, tagged with the requester index, through a valid/ready response port. It sits between the requester-side logic and the shared adder instance.

## Interface
- `NREQ`, default 4: number of requesters; minimum 2.
- `W`, default 4: operand width; sum width is `W+1`.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i offers an operand pair.
- `req_a`  in  NREQ*W  operand a; requester i occupies bits `[i*W +: W]`.
- `req_b`  in  NREQ*W  operand b; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot or zero; bit i set means requester i's pair is accepted this cycle.
- `add_a`  out  W  operand a to the shared adder (registered).
- `add_b`  out  W  operand b to the shared adder (registered).
- `add_sum`  in  W+1  registered sum from the shared adder.
- `rsp_valid`  out  1  response available.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sum`  out  W+1  result.
- `rsp_ready`  in  1  response consumer accepts.

## Operation
- FSM states:
  - IDLE: if any `req_valid` bit is set, grant the round-robin winner `g`.
    - `req_ready[g]=1` combinationally; the transfer completes at this edge.
    - Register `add_a<=req_a[g]`, `add_b<=req_b[g]`, `id<=g`, `last<=g`.
    - Next state: ISSUE.
  - ISSUE: `add_a`/`add_b` are stable; the adder samples them at the end of this cycle. Next state: CAPT.
  - CAPT: `add_sum` is valid. Register `rsp_sum<=add_sum`, `rsp_id<=id`, `rsp_valid<=1`. Next state: RESP.
  - RESP: hold `rsp_valid`, `rsp_id` and `rsp_sum` until `rsp_ready=1`. At that edge, clear `rsp_valid` and go to IDLE.
- `req_ready` is all-zero in every state except IDLE, and all-zero while `rst=1`.
- Round-robin search:
  - Scan indices `last+1`, `last+2`, … modulo `NREQ`; the first index with `req_valid` set wins.
  - `last` resets to `NREQ-1`, so requester 0 has first priority after reset.
- `add_a`/`add_b` hold their value outside IDLE grants; they are not cleared after use.
- Arithmetic: the adder produces `W+1` bits, so no overflow is possible. `rsp_sum` is copied without modification (e.g. W=4: 15+15 gives 30 = 5'b11110).
- Requester side: requesters hold `req_valid`, `req_a` and `req_b` stable until they see `req_ready`. The scheduler does not sample operands outside the grant cycle.
- Reset mid-operation: `rst` wins over all other inputs.
  - State returns to IDLE and `last` to `NREQ-1`.
  - Any in-flight transaction is dropped; no response is issued for it.
- Reset values: `req_ready=0`, `add_a=0`, `add_b=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`.

## Timing
- Accept at edge E0; `rsp_valid=1` is visible after E2, i.e. two cycles of latency.
- Throughput: at most one transaction every 4 cycles, reached when `rsp_ready` is held at 1.
- `rsp_ready` low for k cycles extends RESP by k cycles. No new grant is made until the response is consumed.
- A request that arrives while the scheduler is busy waits. It is considered at the next IDLE cycle.
- Simultaneous requests get exactly one grant per IDLE visit. With all requesters valid, grants rotate 0,1,2,…,NREQ-1,0.

## Configuration
- `ADD_SCHED_FIXED_PRIO_EN`:
  - Defined: arbitration is fixed priority; the lowest set index of `req_valid` wins. `last` is still tracked but ignored.
  - Undefined (default): round-robin as described above.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Single request: `rst` released; requester 2 offers a=3, b=5 with `rsp_ready=1`.
  - Required: `req_ready=4'b0100` for one cycle.
  - Required: two cycles later `rsp_valid=1`, `rsp_id=2`, `rsp_sum=8`; back to IDLE the following cycle.
- All four requesters valid, with a=i, b=10 for requester i, and `rsp_ready=1`.
  - Required: responses in id order 0,1,2,3 with sums 10,11,12,13, spaced 4 cycles apart.
  - Under `ADD_SCHED_FIXED_PRIO_EN`, with requester 0 re-asserting after each grant: requester 0 wins every time.
- Backpressure: one request, a=7, b=9, with `rsp_ready=0` for 5 cycles.
  - Required: `rsp_valid`, `rsp_id` and `rsp_sum=16` stay stable, and `req_ready` stays 0 throughout.
  - Required: the response is consumed on the first cycle `rsp_ready=1`.
- Maximum operands: a=15, b=15.
  - Required: `rsp_sum=30`; no truncation.
- Reset mid-operation: assert `rst` for one cycle while in CAPT.
  - Required: `rsp_valid` stays 0, and no response is produced for the dropped request.
  - Required: the next grant goes to requester 0 when requesters 0 and 1 are both valid.
